// File: rtl/ahb_cmd_master_if.sv
// ----------------------------------------------------------------------------
// ahb_cmd_master_if
//
// Purpose: bundles the three signal groups around ahb_cmd_master.
//   * command stream   (requester -> ahb_cmd_master)
//   * response stream  (ahb_cmd_master -> requester)
//   * AHB-Lite initiator bus (ahb_cmd_master <-> slave/interconnect)
//
// Handshake semantics (both streams): a beat transfers on a rising clock
// edge where valid and ready are both high. Once valid is raised, the
// sender keeps valid and the payload stable until that edge. The receiver
// may raise or drop ready at any time; ready never depends on valid
// combinationally.
//
// Modports:
//   master : the side that implements the initiator (ahb_cmd_master itself)
//   slave  : the opposite side (requester plus AHB slave), e.g. a bench
// ----------------------------------------------------------------------------
interface ahb_cmd_master_if;

    // Command stream
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;

    // Response stream
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;

    // AHB-Lite initiator signals
    logic [31:0] haddr_m;
    logic [2:0]  hburst_m;
    logic [2:0]  hsize_m;
    logic [1:0]  htrans_m;
    logic        hwrite_m;
    logic [31:0] hwdata_m;
    logic [31:0] hrdata_m;
    logic        hready_m;
    logic        hresp_m;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_status,
        input  rsp_ready,
        output haddr_m, hburst_m, hsize_m, htrans_m, hwrite_m, hwdata_m,
        input  hrdata_m, hready_m, hresp_m
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_status,
        output rsp_ready,
        input  haddr_m, hburst_m, hsize_m, htrans_m, hwrite_m, hwdata_m,
        output hrdata_m, hready_m, hresp_m
    );

endinterface : ahb_cmd_master_if

// File: rtl/ahb_cmd_master.sv
// ----------------------------------------------------------------------------
// ahb_cmd_master
//
// Purpose: single-transfer, non-pipelined AHB-Lite initiator. Each accepted
// command becomes one SINGLE transfer (or is rejected without touching the
// bus when its size/alignment is illegal); the outcome comes back as one
// response beat. At most one transfer is outstanding.
//
// Parameters:
//   TIMEOUT : consecutive stalled data-phase cycles before a transfer is
//             abandoned with TIMEOUT status; 0 disables the timeout
//   TW      : timeout counter width, TIMEOUT must be below 2**TW
//
// Ports:
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   bus         : ahb_cmd_master_if.master (command, response, AHB groups)
//   o_dbg_state : current FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 RESP)
//
// Response status codes: 0 OKAY, 1 bus ERROR, 2 TIMEOUT, 3 REJECTED.
// All outputs are registered.
// ----------------------------------------------------------------------------
module ahb_cmd_master #(
    parameter int TIMEOUT = 256,
    parameter int TW      = 9
) (
    input  logic                clk,
    input  logic                reset_n,
    ahb_cmd_master_if.master    bus,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] RSP_OKAY    = 2'd0;
    localparam logic [1:0] RSP_ERROR   = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;
    localparam logic [1:0] RSP_REJECT  = 2'd3;

    // Counter value on which the next stalled cycle is the TIMEOUT-th one.
    // Only meaningful when TIMEOUT != 0.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_SAT  = {TW{1'b1}};

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_status;
    logic [31:0] r_haddr;
    logic [2:0]  r_hsize;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [31:0] r_hwdata;
    logic [31:0] r_wdata;
    logic [TW-1:0] r_to_cnt;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_reject;

    assign w_accept     = bus.cmd_valid && r_cmd_ready;
    assign w_misaligned = ((bus.cmd_size == 3'd1) && bus.cmd_addr[0]) ||
                          ((bus.cmd_size == 3'd2) && (bus.cmd_addr[1:0] != 2'b00));
    assign w_reject     = w_misaligned || (bus.cmd_size > 3'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 32'd0;
            r_rsp_status <= RSP_OKAY;
            r_haddr      <= 32'd0;
            r_hsize      <= 3'd0;
            r_htrans     <= HTRANS_IDLE;
            r_hwrite     <= 1'b0;
            r_hwdata     <= 32'd0;
            r_wdata      <= 32'd0;
            r_to_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (w_reject) begin
                            // Illegal commands never reach the bus.
                            r_rsp_valid  <= 1'b1;
                            r_rsp_status <= RSP_REJECT;
                            r_rsp_rdata  <= 32'd0;
                            r_state      <= S_RESP;
                        end else begin
                            r_haddr  <= bus.cmd_addr;
                            r_hsize  <= bus.cmd_size;
                            r_hwrite <= bus.cmd_write;
                            r_wdata  <= bus.cmd_wdata;
                            r_htrans <= HTRANS_NONSEQ;
                            r_state  <= S_ADDR;
                        end
                    end
                end

                S_ADDR: begin
                    // Address phase ends on the first edge with HREADY high.
                    if (bus.hready_m) begin
                        r_htrans <= HTRANS_IDLE;
                        r_hwdata <= r_hwrite ? r_wdata : 32'd0;
                        r_to_cnt <= '0;
                        r_state  <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bus.hready_m) begin
                        r_rsp_valid <= 1'b1;
                        r_hwdata    <= 32'd0;
                        if (bus.hresp_m) begin
                            r_rsp_status <= RSP_ERROR;
                            r_rsp_rdata  <= 32'd0;
                        end else begin
                            r_rsp_status <= RSP_OKAY;
                            r_rsp_rdata  <= r_hwrite ? 32'd0 : bus.hrdata_m;
                        end
                        r_state <= S_RESP;
                    end else if ((TIMEOUT != 0) && (r_to_cnt == TO_LAST)) begin
                        // This is the TIMEOUT-th consecutive stalled cycle.
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= RSP_TIMEOUT;
                        r_rsp_rdata  <= 32'd0;
                        r_hwdata     <= 32'd0;
                        r_state      <= S_RESP;
                    end else if (r_to_cnt != TO_SAT) begin
                        // First half of a two-cycle ERROR also lands here.
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_status = r_rsp_status;
    assign bus.haddr_m    = r_haddr;
    assign bus.hburst_m   = 3'b000;
    assign bus.hsize_m    = r_hsize;
    assign bus.htrans_m   = r_htrans;
    assign bus.hwrite_m   = r_hwrite;
    assign bus.hwdata_m   = r_hwdata;
    assign o_dbg_state    = r_state;

endmodule : ahb_cmd_master

// File: tb/tb_ahb_cmd_master.sv
module tb_ahb_cmd_master;

  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ahb_cmd_master_if bus ();
  logic [1:0] dbg_state;

  ahb_cmd_master #(.TIMEOUT(TIMEOUT), .TW(9)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int nonseq_cnt = 0;
  bit bus_bad = 1'b0;
  bit prev_rv = 1'b0;

  logic [33:0] exp_q[$];   // {status, rdata}
  int          acc_q[$];   // accept cycle
  int          lat_q[$];   // expected accept->rsp_valid latency

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.htrans_m == 2'b10) nonseq_cnt++;
    if (!(bus.htrans_m inside {2'b00, 2'b10}) || bus.hburst_m != 3'b000) bus_bad = 1'b1;
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [33:0] e;
    int a;
    int l;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid && !prev_rv) begin
        check_val("rsp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          l = lat_q.pop_front();
          check_val("rsp_status", bus.rsp_status, e[33:32]);
          check_val("rsp_rdata", bus.rsp_rdata, e[31:0]);
          check_val("rsp_latency", cyc - a, l);
        end
      end
      prev_rv = bus.rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wd, input logic [1:0] est,
                           input logic [31:0] erd, input int elat);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("cmd_ready_wait", n < 50, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_size  = size;
    bus.cmd_wdata = wd;
    exp_q.push_back({est, erd});
    acc_q.push_back(cyc);
    lat_q.push_back(elat);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_size  = 3'($urandom_range(0, 7));
    bus.cmd_wdata = $urandom;
  endtask

  // AHB slave for one transfer: waits stalled cycles (hresp raised on the
  // last one when err, giving the two-cycle ERROR), or stalls until the
  // response appears when stall is set.
  task automatic slave_xfer(input int waits, input bit err, input bit stall,
                            input logic [31:0] rd, input logic [31:0] eaddr,
                            input bit ewr, input logic [2:0] esize, input logic [31:0] ewd);
    int n = 0;
    @(negedge clk);
    while (bus.htrans_m != 2'b10 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("nonseq_seen", n < 50, 1);
    check_val("haddr", bus.haddr_m, eaddr);
    check_val("hwrite", bus.hwrite_m, ewr);
    check_val("hsize", bus.hsize_m, esize);
    @(negedge clk);
    check_val("htrans_data", bus.htrans_m, 2'b00);
    check_val("hwdata", bus.hwdata_m, ewd);
    if (stall) begin
      bus.hready_m = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_val("stall_end", n < 50, 1);
      bus.hready_m = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++) begin
        bus.hready_m = 1'b0;
        bus.hresp_m  = err && (i == waits - 1);
        @(negedge clk);
        check_val("htrans_wait", bus.htrans_m, 2'b00);
        check_val("hwdata_hold", bus.hwdata_m, ewd);
      end
      bus.hready_m = 1'b1;
      bus.hresp_m  = err;
      bus.hrdata_m = rd;
      @(negedge clk);
      bus.hresp_m  = 1'b0;
      bus.hrdata_m = $urandom;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_done", n < 100, 1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_cmd_ready"}, bus.cmd_ready, 0);
    check_val({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
    check_val({pfx, "_rsp_rdata"}, bus.rsp_rdata, 0);
    check_val({pfx, "_rsp_status"}, bus.rsp_status, 0);
    check_val({pfx, "_haddr"}, bus.haddr_m, 0);
    check_val({pfx, "_hsize"}, bus.hsize_m, 0);
    check_val({pfx, "_htrans"}, bus.htrans_m, 0);
    check_val({pfx, "_hwrite"}, bus.hwrite_m, 0);
    check_val({pfx, "_hwdata"}, bus.hwdata_m, 0);
    check_val({pfx, "_state"}, dbg_state, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int ns0;
    int n;
    bit wr;
    int waits;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.hrdata_m  = 32'hA5A5_5A5A;
    bus.hready_m  = 1'b1;
    bus.hresp_m   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    check_val("rst_hburst", bus.hburst_m, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("idle_cmd_ready", bus.cmd_ready, 1);

    // Zero-wait write
    ns0 = nonseq_cnt;
    fork
      drive_cmd(1'b1, 32'h8, 3'd2, 32'h000A_0005, 2'd0, 32'h0, 3);
      slave_xfer(0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h8, 1'b1, 3'd2, 32'h000A_0005);
    join
    wait_drain();
    check_val("wr_nonseq_cycles", nonseq_cnt - ns0, 1);

    // Read with 3 wait states
    ns0 = nonseq_cnt;
    fork
      drive_cmd(1'b0, 32'h4, 3'd2, 32'h5555_AAAA, 2'd0, 32'h1234_5678, 6);
      slave_xfer(3, 1'b0, 1'b0, 32'h1234_5678, 32'h4, 1'b0, 3'd2, 32'h0);
    join
    wait_drain();
    check_val("rd_nonseq_cycles", nonseq_cnt - ns0, 1);

    // Two-cycle ERROR response
    fork
      drive_cmd(1'b0, 32'hC, 3'd2, 32'h0, 2'd1, 32'h0, 4);
      slave_xfer(1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hC, 1'b0, 3'd2, 32'h0);
    join
    wait_drain();

    // Timeout
    fork
      drive_cmd(1'b1, 32'h20, 3'd2, 32'h7777_0001, 2'd2, 32'h0, 6);
      slave_xfer(0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h20, 1'b1, 3'd2, 32'h7777_0001);
    join
    wait_drain();
    check_val("to_back_idle", dbg_state, 0);
    @(negedge clk);
    check_val("to_cmd_ready", bus.cmd_ready, 1);

    // Rejected commands: misaligned word, size 3, odd halfword
    ns0 = nonseq_cnt;
    drive_cmd(1'b1, 32'h2, 3'd2, 32'h1111_2222, 2'd3, 32'h0, 1);
    wait_drain();
    drive_cmd(1'b0, 32'h0, 3'd3, 32'h0, 2'd3, 32'h0, 1);
    wait_drain();
    drive_cmd(1'b0, 32'h101, 3'd1, 32'h0, 2'd3, 32'h0, 1);
    wait_drain();
    check_val("rej_nonseq_cycles", nonseq_cnt - ns0, 0);

    // Response backpressure
    bus.rsp_ready = 1'b0;
    fork
      drive_cmd(1'b0, 32'h30, 3'd2, 32'h0, 2'd0, 32'hCAFE_F00D, 3);
      slave_xfer(0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h30, 1'b0, 3'd2, 32'h0);
    join
    for (int i = 0; i < 5; i++) begin
      check_val("bp_rsp_valid", bus.rsp_valid, 1);
      check_val("bp_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
      check_val("bp_rsp_status", bus.rsp_status, 0);
      check_val("bp_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    wait_drain();

    // Reset asserted while in DATA
    fork
      drive_cmd(1'b0, 32'h40, 3'd2, 32'h0, 2'd0, 32'h0, 3);
      begin
        n = 0;
        @(negedge clk);
        while (bus.htrans_m != 2'b10 && n < 50) begin
          @(negedge clk);
          n++;
        end
        check_val("rstd_nonseq_seen", n < 50, 1);
        @(negedge clk);
        bus.hready_m = 1'b0;
        @(negedge clk);
        check_val("rstd_in_data", dbg_state, 2);
        #2 reset_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        #1 check_reset_vals("rstd");
        @(negedge clk);
        bus.hready_m = 1'b1;
        reset_n = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    check_val("rstd_no_rsp", bus.rsp_valid, 0);
    fork
      drive_cmd(1'b1, 32'h44, 3'd2, 32'h0BAD_F00D, 2'd0, 32'h0, 3);
      slave_xfer(0, 1'b0, 1'b0, 32'h1357_9BDF, 32'h44, 1'b1, 3'd2, 32'h0BAD_F00D);
    join
    wait_drain();

    // Random legal transfers with random wait states
    for (int k = 0; k < 6; k++) begin
      wr    = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 2);
      addr  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      addr  = {2'b00, addr[31:2]} << 2;
      wd    = $urandom;
      rd    = $urandom;
      fork
        drive_cmd(wr, addr, 3'd2, wd, 2'd0, wr ? 32'h0 : rd, 3 + waits);
        slave_xfer(waits, 1'b0, 1'b0, rd, addr, wr, 3'd2, wr ? wd : 32'h0);
      join
      wait_drain();
    end

    check_val("bus_rules", bus_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ahb_cmd_master
